// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline stages: load-size encodings and
// datapath-width helpers used by the MEM->WB stage and the load aligner.
package mips_pipe_pkg;

  // Load access size as carried down the pipe from decode.
  typedef enum logic [1:0] {
    LD_BYTE  = 2'b00,
    LD_HALF  = 2'b01,
    LD_WORD  = 2'b10,
    LD_DWORD = 2'b11
  } load_size_e;

  // Only 32- and 64-bit datapaths are supported by the core.
  function automatic bit data_w_legal(input int w);
    return (w == 32) || (w == 64);
  endfunction

  // Number of address bits that select a byte lane within a data word.
  function automatic int lane_off_w(input int w);
    return (w == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational sub-word load aligner: picks the addressed field out of a
// full little-endian memory word and zero/sign-extends it to DATA_W.
// Also used by the cache refill path, so it carries no state.
module load_align #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = 2
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OFF_W-1:0]  offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] value
);
  import mips_pipe_pkg::*;

  localparam logic [DATA_W-1:0] ONE_V      = DATA_W'(1);
  localparam logic [DATA_W-1:0] ALL_ONES_V = {DATA_W{1'b1}};
  // Lane masks that drop the low offset bits for naturally aligned halves/words.
  localparam logic [OFF_W-1:0]  HALF_MASK  = ~OFF_W'(1);
  localparam logic [OFF_W-1:0]  WORD_MASK  = ~OFF_W'(3);

  logic [OFF_W-1:0]  lane_s;
  logic [6:0]        field_w_s;
  logic [DATA_W-1:0] shifted_s;
  logic [DATA_W-1:0] keep_mask_s;
  logic [DATA_W-1:0] sign_mask_s;
  logic              sign_bit_s;

  // Choose the starting lane and field width for the requested access size.
  always_comb begin
    lane_s    = {OFF_W{1'b0}};
    field_w_s = 7'd32;
    case (size)
      LD_BYTE: begin
        lane_s    = offset;
        field_w_s = 7'd8;
      end
      LD_HALF: begin
        lane_s    = offset & HALF_MASK;
        field_w_s = 7'd16;
      end
      LD_WORD: begin
        lane_s    = offset & WORD_MASK;
        field_w_s = 7'd32;
      end
      LD_DWORD: begin
        // A 32-bit datapath has no dword loads; fall back to a word access.
        if (DATA_W == 64) begin
          lane_s    = {OFF_W{1'b0}};
          field_w_s = 7'd64;
        end else begin
          lane_s    = offset & WORD_MASK;
          field_w_s = 7'd32;
        end
      end
      default: begin
        lane_s    = {OFF_W{1'b0}};
        field_w_s = 7'd32;
      end
    endcase
  end

  // Shift the field down to bit 0, then mask and extend it to full width.
  always_comb begin
    shifted_s   = rdata >> {lane_s, 3'b000};
    // Shifting all-ones by the full width yields zero, so a full-width field keeps everything.
    keep_mask_s = ~(ALL_ONES_V << field_w_s);
    sign_mask_s = ONE_V << (field_w_s - 7'd1);
    sign_bit_s  = |(shifted_s & sign_mask_s);
    if (sign_bit_s && !is_unsigned) begin
      value = (shifted_s & keep_mask_s) | ~keep_mask_s;
    end else begin
      value = shifted_s & keep_mask_s;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register of the 5-stage MIPS core. Captures the ALU result,
// aligned load data and write-back control, supports stall/flush and counts
// retired instructions. Outputs feed the register file and forwarding network.
module mem_wb_stage #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int CNT_W    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic               in_reg_write,
  input  logic               in_mem_to_reg,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]  in_alu_result,
  input  logic [DATA_W-1:0]  in_mem_rdata,
  input  logic [1:0]         in_load_size,
  input  logic               in_load_unsigned,
  input  logic               cnt_clear,
  output logic               wb_valid,
  output logic               wb_reg_write,
  output logic [RADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]  wb_data,
  output logic [CNT_W-1:0]   retire_count
);
  import mips_pipe_pkg::*;

  localparam int OFF_W = lane_off_w(DATA_W);

  if (!data_w_legal(DATA_W)) begin : g_illegal_data_w
    $error("mem_wb_stage: DATA_W must be 32 or 64");
  end

  logic [DATA_W-1:0]  aligned_s;
  logic [DATA_W-1:0]  wb_value_s;
  logic               rd_blocked_s;
  logic               reg_write_s;
  logic               capture_s;

  logic               wb_valid_r;
  logic               wb_reg_write_r;
  logic [RADDR_W-1:0] wb_rd_r;
  logic [DATA_W-1:0]  wb_data_r;
  logic [CNT_W-1:0]   retire_count_r;

  load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_align (
    .rdata       (in_mem_rdata),
    .offset      (in_alu_result[OFF_W-1:0]),
    .size        (in_load_size),
    .is_unsigned (in_load_unsigned),
    .value       (aligned_s)
  );

  // Write-back mux, zero-register suppression and capture qualification.
  always_comb begin
    if (in_mem_to_reg) begin
      wb_value_s = aligned_s;
    end else begin
      wb_value_s = in_alu_result;
    end
    rd_blocked_s = (ZERO_REG != 0) && (in_rd == {RADDR_W{1'b0}});
    reg_write_s  = in_valid && in_reg_write && !rd_blocked_s;
    capture_s    = !flush && !stall;
  end

  // Stage registers: flush inserts a bubble, stall holds, otherwise capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_r     <= 1'b0;
      wb_reg_write_r <= 1'b0;
      wb_rd_r        <= {RADDR_W{1'b0}};
      wb_data_r      <= {DATA_W{1'b0}};
    end else if (flush) begin
      // rd/data are left as-is; only the valid/write qualifiers are killed.
      wb_valid_r     <= 1'b0;
      wb_reg_write_r <= 1'b0;
    end else if (!stall) begin
      wb_valid_r     <= in_valid;
      wb_reg_write_r <= reg_write_s;
      wb_rd_r        <= in_rd;
      wb_data_r      <= wb_value_s;
    end else begin
      wb_valid_r     <= wb_valid_r;
      wb_reg_write_r <= wb_reg_write_r;
      wb_rd_r        <= wb_rd_r;
      wb_data_r      <= wb_data_r;
    end
  end

  // Retire counter: clear beats increment and is honoured even while stalled/flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_count_r <= {CNT_W{1'b0}};
    end else if (cnt_clear) begin
      retire_count_r <= {CNT_W{1'b0}};
    end else if (capture_s && in_valid) begin
      retire_count_r <= retire_count_r + CNT_W'(1);
    end else begin
      retire_count_r <= retire_count_r;
    end
  end

  assign wb_valid     = wb_valid_r;
  assign wb_reg_write = wb_reg_write_r;
  assign wb_rd        = wb_rd_r;
  assign wb_data      = wb_data_r;
  assign retire_count = retire_count_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (DATA_W=32, CNT_W=4, ZERO_REG=1).
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_rdata;
  logic [1:0]  in_load_size;
  logic        in_load_unsigned;
  logic        cnt_clear;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  retire_count;

  int checks;
  int errors;

  mem_wb_stage #(
    .DATA_W   (32),
    .RADDR_W  (5),
    .CNT_W    (4),
    .ZERO_REG (1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_reg_write     (in_reg_write),
    .in_mem_to_reg    (in_mem_to_reg),
    .in_rd            (in_rd),
    .in_alu_result    (in_alu_result),
    .in_mem_rdata     (in_mem_rdata),
    .in_load_size     (in_load_size),
    .in_load_unsigned (in_load_unsigned),
    .cnt_clear        (cnt_clear),
    .wb_valid         (wb_valid),
    .wb_reg_write     (wb_reg_write),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .retire_count     (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [1:0] sz, input logic uns);
    in_valid         = v;
    in_reg_write     = rw;
    in_mem_to_reg    = m2r;
    in_rd            = rd;
    in_alu_result    = alu;
    in_mem_rdata     = rdata;
    in_load_size     = sz;
    in_load_unsigned = uns;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    stall     = 1'b0;
    flush     = 1'b0;
    cnt_clear = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", wb_valid, 1'b0);
    check("rst_rw", wb_reg_write, 1'b0);
    check("rst_rd", wb_rd, 5'd0);
    check("rst_data", wb_data, 32'h0);
    check("rst_cnt", retire_count, 4'd0);
    @(negedge clk);
    reset = 1'b0;

    // Byte signed at lane 3.
    drive(1'b1, 1'b1, 1'b1, 5'd5, 32'h0000_1003, 32'h8A7F_1280, 2'b00, 1'b0);
    step();
    check("byte_s_data", wb_data, 32'hFFFF_FF8A);
    check("byte_s_valid", wb_valid, 1'b1);
    check("byte_s_rw", wb_reg_write, 1'b1);
    check("byte_s_rd", wb_rd, 5'd5);
    check("byte_s_cnt", retire_count, 4'd1);

    // Byte unsigned at lane 3.
    drive(1'b1, 1'b1, 1'b1, 5'd6, 32'h0000_1003, 32'h8A7F_1280, 2'b00, 1'b1);
    step();
    check("byte_u_data", wb_data, 32'h0000_008A);
    check("byte_u_cnt", retire_count, 4'd2);

    // Half signed, lane 2.
    drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h0000_2002, 32'h8001_1234, 2'b01, 1'b0);
    step();
    check("half_a2", wb_data, 32'hFFFF_8001);

    // Half at odd address 1: bit 0 ignored, lane 0.
    drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h0000_2001, 32'h8001_1234, 2'b01, 1'b0);
    step();
    check("half_a1", wb_data, 32'h0000_1234);

    // Byte signed at lane 0 (0x80).
    drive(1'b1, 1'b1, 1'b1, 5'd8, 32'h0000_3000, 32'h8A7F_1280, 2'b00, 1'b0);
    step();
    check("byte_a0", wb_data, 32'hFFFF_FF80);

    // Word at address 3: low bits ignored.
    drive(1'b1, 1'b1, 1'b1, 5'd8, 32'h0000_3003, 32'h8A7F_1280, 2'b10, 1'b0);
    step();
    check("word_a3", wb_data, 32'h8A7F_1280);

    // Size 11 on a 32-bit datapath behaves as word.
    drive(1'b1, 1'b1, 1'b1, 5'd8, 32'h0000_3002, 32'h8A7F_1280, 2'b11, 1'b0);
    step();
    check("dword_as_word", wb_data, 32'h8A7F_1280);
    check("dword_cnt", retire_count, 4'd7);

    // ALU path to register 0: write suppressed, still retires.
    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h8A7F_1280, 2'b00, 1'b0);
    step();
    check("r0_data", wb_data, 32'hDEAD_BEEF);
    check("r0_valid", wb_valid, 1'b1);
    check("r0_rw", wb_reg_write, 1'b0);
    check("r0_cnt", retire_count, 4'd8);

    // Invalid instruction still captures data but never writes or retires.
    drive(1'b0, 1'b1, 1'b0, 5'd7, 32'h1234_5678, 32'h0, 2'b10, 1'b0);
    step();
    check("inv_valid", wb_valid, 1'b0);
    check("inv_rw", wb_reg_write, 1'b0);
    check("inv_rd", wb_rd, 5'd7);
    check("inv_data", wb_data, 32'h1234_5678);
    check("inv_cnt", retire_count, 4'd8);

    // Capture a reference write, then stall for three cycles with new inputs.
    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'hCAFE_F00D, 32'h0, 2'b10, 1'b0);
    step();
    check("pre_stall_cnt", retire_count, 4'd9);
    drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h1111_1111, 32'h0, 2'b10, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_data", wb_data, 32'hCAFE_F00D);
      check("stall_rd", wb_rd, 5'd9);
      check("stall_valid", wb_valid, 1'b1);
      check("stall_rw", wb_reg_write, 1'b1);
      check("stall_cnt", retire_count, 4'd9);
    end

    // Flush together with stall: bubble wins, rd/data held.
    flush = 1'b1;
    step();
    check("flush_valid", wb_valid, 1'b0);
    check("flush_rw", wb_reg_write, 1'b0);
    check("flush_data", wb_data, 32'hCAFE_F00D);
    check("flush_rd", wb_rd, 5'd9);
    check("flush_cnt", retire_count, 4'd9);

    // Flush alone with a valid input: still no retire.
    stall = 1'b0;
    step();
    check("flush2_valid", wb_valid, 1'b0);
    check("flush2_cnt", retire_count, 4'd9);
    flush = 1'b0;

    // Clear beats a simultaneous valid capture.
    drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_0042, 32'h0, 2'b10, 1'b0);
    cnt_clear = 1'b1;
    step();
    check("clr_cnt", retire_count, 4'd0);
    check("clr_valid", wb_valid, 1'b1);
    check("clr_data", wb_data, 32'h0000_0042);
    cnt_clear = 1'b0;

    // Sixteen captures wrap the 4-bit counter back to zero.
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 15) check("cnt_15", retire_count, 4'd15);
    end
    check("cnt_wrap", retire_count, 4'd0);
    step();
    check("cnt_after_wrap", retire_count, 4'd1);

    // Clear honoured while stalled.
    stall     = 1'b1;
    cnt_clear = 1'b1;
    step();
    check("clr_stall_cnt", retire_count, 4'd0);
    check("clr_stall_valid", wb_valid, 1'b1);
    stall     = 1'b0;
    cnt_clear = 1'b0;

    // Asynchronous reset in the middle of a cycle with a valid write pending.
    drive(1'b1, 1'b1, 1'b0, 5'd12, 32'hA5A5_5A5A, 32'h0, 2'b10, 1'b0);
    step();
    check("pre_rst_valid", wb_valid, 1'b1);
    check("pre_rst_cnt", retire_count, 4'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", wb_valid, 1'b0);
    check("mid_rst_rw", wb_reg_write, 1'b0);
    check("mid_rst_rd", wb_rd, 5'd0);
    check("mid_rst_data", wb_data, 32'h0);
    check("mid_rst_cnt", retire_count, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("post_rst_valid", wb_valid, 1'b0);
    check("post_rst_rw", wb_reg_write, 1'b0);
    check("post_rst_cnt", retire_count, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
